screen_scanout: RTL and testbench
=================================

Name: screen_scanout

Overview:
- Read-side consumer of the memory-mapped screen buffer: the CPU writes the buffer, this block reads it back continuously and serialises it into a raster pixel stream with sync pulses.
- It generates horizontal and vertical counters, fetches 16-bit screen words through a read port with 1-cycle latency, and shifts pixels out one per clock.
- It attaches to a second (read-only) port of the screen RAM at screen base offset 0.

Parameters:
- H_ACTIVE, 512, visible pixels per line; a multiple of 16. WORDS_PER_ROW = H_ACTIVE/16.
- H_BLANK, 64, blank pixels per line. H_TOTAL = H_ACTIVE + H_BLANK.
- V_ACTIVE, 256, visible lines per frame.
- V_BLANK, 8, blank lines per frame. V_TOTAL = V_ACTIVE + V_BLANK.
- HSYNC_LEN, 32, hsync width in pixels; requires HSYNC_LEN <= H_BLANK.
- VSYNC_LINES, 2, vsync width in lines; requires VSYNC_LINES <= V_BLANK.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run scanout while high.
- rd_en  out  1  screen read strobe.
- rd_addr  out  13  screen word address.
- rd_data  in  16  word addressed by rd_en, valid exactly 1 cycle after rd_en.
- pixel  out  1  current pixel, 1 = black.
- pixel_valid  out  1  high during visible pixels.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.
- frame_start  out  1  1-cycle pulse aligned with pixel (0,0).
- frame_count  out  8  completed frames, wraps 255 -> 0.

Behaviour:
- Reset: state IDLE, counters h=v=0, shift register 0, delay pipelines 0. All outputs are 0, including rd_addr and frame_count.
- State machine:
  - IDLE: counters held at 0. If enable=1, go to RUN next cycle.
  - RUN with enable=0: go to IDLE next cycle, counters cleared.
  - enable is sampled every cycle.
- Counters, RUN only:
  - h increments each cycle; at h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h wrap, v wraps to 0 and frame_count increments.
- Fetch:
  - rd_en = RUN && h<H_ACTIVE && v<V_ACTIVE && h[3:0]==0. Combinational from registered state.
  - rd_addr = v*WORDS_PER_ROW + h/16, truncated to 13 bits; 0 when rd_en=0.
  - Exactly WORDS_PER_ROW reads per active line, 16 cycles apart. No reads in blanking.
- Pixel path:
  - The cycle after rd_en, rd_data loads the 16-bit shift register.
  - Otherwise the register shifts right one place per cycle.
  - pixel = shift[0] registered, so LSB is the leftmost pixel. Pixel (r,c) is bit c%16 of word 32r + c/16 at default width.
- Latency: every output is exactly 2 cycles behind the counter position (h,v) that produced it.
  - pixel_valid = active(h,v) delayed 2.
  - hsync = (H_ACTIVE <= h < H_ACTIVE+HSYNC_LEN) delayed 2.
  - vsync = (V_ACTIVE <= v < V_ACTIVE+VSYNC_LINES) delayed 2.
  - frame_start = (RUN && h==0 && v==0) delayed 2.
  - pixel = 0 whenever pixel_valid = 0.
- Stop / reset mid-frame:
  - enable low: rd_en drops the next cycle. The delay pipelines keep shifting zeros in, so all stream outputs are 0 within 2 cycles; no partial word is emitted afterwards.
  - Re-enable always starts at (0,0).
  - reset mid-frame: identical behaviour, and frame_count clears.
- Simultaneous events: reset has priority over enable. If enable rises the same cycle reset deasserts, IDLE->RUN occurs the following cycle.
- Frame length is exactly H_TOTAL*V_TOTAL cycles. frame_start spacing equals that while enable stays high.

Test Plan (params: H_ACTIVE=32, H_BLANK=4, V_ACTIVE=2, V_BLANK=1, HSYNC_LEN=2, VSYNC_LINES=1; frame = 108 cycles):
- Reset for 3 cycles with enable=1 -> all outputs 0, no rd_en; first rd_en (addr 0) 1 cycle after reset release; first frame_start 2 cycles after that.
- Screen words [0]=0x0001, [1]=0x8000, [2]=0x00FF, [3]=0x0000 -> line 0 emits 1, then 30 zeros, then 1; line 1 emits 8 ones then 24 zeros; pixel_valid high for 32 cycles per line, then low 4.
- Over one frame -> exactly 4 rd_en pulses at addresses 0,1,2,3 at h=0,16 of v=0,1; none during blank.
- Sync checks:
  - hsync high 2 cycles per line, starting 2 cycles after h=32.
  - vsync high for the 36 cycles of line 2.
  - frame_start every 108 cycles.
  - frame_count 0->1->2 across two frames.
- enable dropped at h=20, v=1 -> rd_en 0 next cycle; pixel_valid/pixel 0 within 2 cycles. Re-enable -> rd_addr 0 and frame_start 3 cycles after enable rises (IDLE->RUN 1 cycle, then 2-cycle output latency); frame_count unchanged.
- reset asserted mid-line 0 with frame_count=3 -> next cycle frame_count=0, all outputs 0, counters restart at (0,0).

Source files
------------

// File: rtl/screen_scanout_if.sv
// Read-only port into the screen RAM used by the raster scanout.
// The scanout drives the address/strobe; the RAM returns data one cycle later.
interface screen_scanout_if;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 16;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/screen_scanout.sv
// Raster scanout: walks h/v counters, fetches 16-pixel screen words and
// serialises them LSB-first with sync pulses, all 2 cycles behind the counters.
module screen_scanout #(
    parameter int unsigned H_ACTIVE    = 512,
    parameter int unsigned H_BLANK     = 64,
    parameter int unsigned V_ACTIVE    = 256,
    parameter int unsigned V_BLANK     = 8,
    parameter int unsigned HSYNC_LEN   = 32,
    parameter int unsigned VSYNC_LINES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    screen_scanout_if.master    rd,
    output logic                pixel,
    output logic                pixel_valid,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start,
    output logic [7:0]          frame_count
);
    localparam int unsigned H_TOTAL       = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL       = V_ACTIVE + V_BLANK;
    localparam int unsigned WORDS_PER_ROW = H_ACTIVE / 16;
    localparam int unsigned HW            = $clog2(H_TOTAL);
    localparam int unsigned VW            = $clog2(V_TOTAL);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic [15:0]     shift;
    logic            load_q;
    logic            active_d;
    logic            hsync_d;
    logic            vsync_d;
    logic            fstart_d;

    logic            run;
    logic            active;
    logic            fetch;
    logic            h_end;
    logic            v_end;
    logic            hsync_now;
    logic            vsync_now;
    logic            fstart_now;

    // Position decode from the registered counters.
    always_comb begin
        run        = (state == RUN);
        active     = run && (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        fetch      = active && (h[3:0] == 4'd0);
        h_end      = (32'(h) == H_TOTAL - 1);
        v_end      = (32'(v) == V_TOTAL - 1);
        hsync_now  = run && (32'(h) >= H_ACTIVE) && (32'(h) < H_ACTIVE + HSYNC_LEN);
        vsync_now  = run && (32'(v) >= V_ACTIVE) && (32'(v) < V_ACTIVE + VSYNC_LINES);
        fstart_now = run && (h == '0) && (v == '0);
    end

    assign rd.rd_en   = fetch;
    assign rd.rd_addr = fetch ? 13'(32'(v) * WORDS_PER_ROW + (32'(h) >> 4)) : 13'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            h           <= '0;
            v           <= '0;
            frame_count <= 8'd0;
            shift       <= 16'd0;
            load_q      <= 1'b0;
            active_d    <= 1'b0;
            hsync_d     <= 1'b0;
            vsync_d     <= 1'b0;
            fstart_d    <= 1'b0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_q      <= fetch;
            active_d    <= active;
            hsync_d     <= hsync_now;
            vsync_d     <= vsync_now;
            fstart_d    <= fstart_now;
            pixel_valid <= active_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= fstart_d;

            // The word's first pixel goes straight out; the register keeps the rest.
            if (load_q) begin
                shift <= rd.rd_data >> 1;
                pixel <= active_d & rd.rd_data[0];
            end else begin
                shift <= shift >> 1;
                pixel <= active_d & shift[0];
            end

            if (state == IDLE) begin
                h <= '0;
                v <= '0;
                if (enable) begin
                    state <= RUN;
                end
            end else if (!enable) begin
                state <= IDLE;
                h     <= '0;
                v     <= '0;
            end else if (h_end) begin
                h <= '0;
                if (v_end) begin
                    v           <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    v <= v + VW'(1);
                end
            end else begin
                h <= h + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout at a small raster (36x3, 108-cycle frame)
// with a frame-time reference model and literal spot checks.
module tb_screen_scanout;
    localparam int HA = 32;
    localparam int HB = 4;
    localparam int VA = 2;
    localparam int VB = 1;
    localparam int HS = 2;
    localparam int VS = 1;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FRAME = HT * VT;
    localparam int WPR = HA / 16;
    localparam int LOGN = 1024;

    typedef struct packed {
        logic pix;
        logic pv;
        logic hs;
        logic vs;
        logic fs;
    } strm_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       pixel;
    logic       pixel_valid;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic [7:0] frame_count;

    screen_scanout_if bus ();

    screen_scanout #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .HSYNC_LEN(HS), .VSYNC_LINES(VS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rd          (bus),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Screen RAM read port: data one cycle after the strobe, junk otherwise.
    logic [15:0] mem [0:8191];
    always @(posedge clock) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : 16'hA5C3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: run flag plus time within the frame.
    int m_run = 0;
    int m_t = 0;
    int m_fc = 0;
    strm_t p1 = '0;
    strm_t p2 = '0;

    function automatic strm_t stream_of(input int run_i, input int t_i);
        strm_t s;
        int h;
        int v;
        logic [15:0] w;
        h = t_i % HT;
        v = t_i / HT;
        s = '0;
        if (run_i != 0) begin
            s.pv = (h < HA) && (v < VA);
            if (s.pv) begin
                w = mem[v * WPR + h / 16];
                s.pix = w[h % 16];
            end
            s.hs = (h >= HA) && (h < HA + HS);
            s.vs = (v >= VA) && (v < VA + VS);
            s.fs = (t_i == 0);
        end
        return s;
    endfunction

    always @(posedge clock) begin
        strm_t s;
        s = stream_of(m_run, m_t);
        cyc <= cyc + 1;
        if (reset) begin
            p1 = '0; p2 = '0; m_run = 0; m_t = 0; m_fc = 0;
        end else begin
            p2 = p1;
            p1 = s;
            if (m_run == 0) begin
                if (enable) begin m_run = 1; m_t = 0; end
            end else if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (m_t == FRAME - 1) begin
                m_t = 0;
                m_fc = (m_fc + 1) % 256;
            end else begin
                m_t++;
            end
        end
        started = 1;
    end

    logic        log_rd [0:LOGN-1];
    logic [12:0] log_addr [0:LOGN-1];
    logic        log_pix [0:LOGN-1];
    logic        log_pv [0:LOGN-1];
    logic        log_hs [0:LOGN-1];
    logic        log_vs [0:LOGN-1];
    logic        log_fs [0:LOGN-1];
    logic [7:0]  log_fc [0:LOGN-1];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            int h;
            int v;
            bit e_rd;
            int e_addr;
            h = m_t % HT;
            v = m_t / HT;
            e_rd = (m_run != 0) && (h < HA) && (v < VA) && (h % 16 == 0);
            e_addr = e_rd ? v * WPR + h / 16 : 0;
            check("rd_en", 32'(bus.rd_en), 32'(e_rd));
            check("rd_addr", 32'(bus.rd_addr), 32'(e_addr));
            check("pixel", 32'(pixel), 32'(p2.pix));
            check("pixel_valid", 32'(pixel_valid), 32'(p2.pv));
            check("hsync", 32'(hsync), 32'(p2.hs));
            check("vsync", 32'(vsync), 32'(p2.vs));
            check("frame_start", 32'(frame_start), 32'(p2.fs));
            check("frame_count", 32'(frame_count), 32'(m_fc));
            if (cyc < LOGN) begin
                log_rd[cyc]   = bus.rd_en;
                log_addr[cyc] = bus.rd_addr;
                log_pix[cyc]  = pixel;
                log_pv[cyc]   = pixel_valid;
                log_hs[cyc]   = hsync;
                log_vs[cyc]   = vsync;
                log_fs[cyc]   = frame_start;
                log_fc[cyc]   = frame_count;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rel, f0, d, e, r, n, fs1, fs2, cnt_pv, cnt_hs, cnt_vs;
        int addrs[4];
        int offs[4];
        int exp_off[4];
        logic [31:0] vec;
        exp_off = '{0, 16, 36, 52};

        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        mem[2] = 16'h00FF;
        mem[3] = 16'h0000;

        reset = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rel = cyc;

        for (n = 0; n < 400 && m_fc != 2; n++) tick();
        check("reach_two_frames", 32'(frame_count), 32'd2);

        check("reset_outputs", {19'(0), log_rd[2], log_pix[2], log_pv[2], log_hs[2], log_vs[2], log_fs[2], log_fc[2]}
              | 32'(log_addr[2]), 32'd0);

        f0 = rel + 1;
        check("first_rd_en", 32'(log_rd[rel]) << 1 | 32'(log_rd[f0]), 32'd1);
        n = 0;
        for (int c = f0; c < f0 + FRAME; c++) begin
            if (log_rd[c] === 1'b1) begin
                if (n < 4) begin
                    addrs[n] = int'(log_addr[c]);
                    offs[n] = c - f0;
                end
                n++;
            end
        end
        check("reads_per_frame", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("read_addr", 32'(addrs[k]), 32'(k));
            check("read_offset", 32'(offs[k]), 32'(exp_off[k]));
        end

        fs1 = -1; fs2 = -1;
        for (int c = 1; c < f0 + 2 * FRAME; c++) begin
            if (log_fs[c] === 1'b1) begin
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
        end
        check("first_frame_start", 32'(fs1 - rel), 32'd3);
        check("frame_start_spacing", 32'(fs2 - fs1), 32'd108);

        for (int i = 0; i < 32; i++) vec[i] = log_pix[f0 + 2 + i];
        check("line0_pixels", vec, 32'h8000_0001);
        for (int i = 0; i < 32; i++) vec[i] = log_pix[f0 + 2 + HT + i];
        check("line1_pixels", vec, 32'h0000_00FF);

        cnt_pv = 0; cnt_hs = 0; cnt_vs = 0;
        for (int c = f0 + 2; c < f0 + 2 + FRAME; c++) begin
            cnt_pv += int'(log_pv[c]);
            cnt_hs += int'(log_hs[c]);
            cnt_vs += int'(log_vs[c]);
        end
        check("valid_per_frame", 32'(cnt_pv), 32'd64);
        check("hsync_per_frame", 32'(cnt_hs), 32'd6);
        check("vsync_per_frame", 32'(cnt_vs), 32'd36);
        check("hsync_start", {30'(0), log_hs[f0 + 33], log_hs[f0 + 34]}, 32'd1);
        check("valid_line_edge", {30'(0), log_pv[f0 + 33], log_pv[f0 + 34]}, 32'd2);
        check("fc_first_wrap", {16'(0), log_fc[f0 + 107], log_fc[f0 + 108]}, 32'h0001);

        // Drop enable at h=20 of line 1, then restart.
        for (n = 0; n < 300 && !(m_run != 0 && m_t == HT + 20); n++) tick();
        d = cyc;
        enable = 1'b0;
        repeat (8) tick();
        e = cyc;
        enable = 1'b1;
        repeat (6) tick();
        check("stop_rd_en", 32'(log_rd[d + 1]), 32'd0);
        check("stop_last_pixel", 32'(log_pv[d + 2]), 32'd1);
        check("stop_valid", {30'(0), log_pv[d + 3], log_pix[d + 3]}, 32'd0);
        check("stop_fc_held", 32'(log_fc[d + 5]), 32'd2);
        check("restart_rd", {18'(0), log_rd[e + 1], log_addr[e + 1]}, 32'h2000);
        check("restart_fs", {30'(0), log_fs[e + 2], log_fs[e + 3]}, 32'd1);
        check("restart_fc", 32'(log_fc[e + 3]), 32'd2);

        // Reset mid line 0 of the frame after frame_count reaches 3.
        for (n = 0; n < 300 && !(m_fc == 3 && m_t == 10); n++) tick();
        check("fc_before_reset", 32'(frame_count), 32'd3);
        r = cyc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("reset_fc", 32'(log_fc[r + 1]), 32'd0);
        check("reset_stream", {27'(0), log_rd[r + 1], log_pv[r + 1], log_pv[r + 2], log_pix[r + 1], log_pix[r + 2]}, 32'd0);
        check("reset_restart_rd", {18'(0), log_rd[r + 2], log_addr[r + 2]}, 32'h2000);
        check("reset_restart_fs", 32'(log_fs[r + 4]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
